// File: rtl/elbeth_mem_arb_pkg.sv
// Shared types and constants for the ELBETH two-port memory arbiter.
package elbeth_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_e;

    localparam logic [3:0] RW_READ = 4'b0000;

    // Round-robin pick: sole requester wins, a tie goes to the port not granted last.
    function automatic grant_e pick_winner(input logic a_req, input logic b_req,
                                           input grant_e last);
        if (a_req && (!b_req || last == GNT_B)) begin
            return GNT_A;
        end
        return GNT_B;
    endfunction

endpackage

// File: rtl/elbeth_mem_arb_watchdog.sv
// Access watchdog: counts ACCESS cycles and flags when the memory has had TIMEOUT cycles.
module elbeth_mem_arb_watchdog #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 8'd0;
        end else if (clr) begin
            count <= 8'd0;
        end else if (en && !expired) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/elbeth_memory_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the ELBETH imem (A) and
// dmem (B) ports, with registered memory request and registered responses.
module elbeth_memory_arbiter
    import elbeth_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_en,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [3:0]        a_rw,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_ready,
    output logic              a_error,
    input  logic              b_en,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [3:0]        b_rw,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_ready,
    output logic              b_error,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_rw,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              mem_error,
    output logic              busy
);

    arb_state_e state;
    grant_e     grant;
    grant_e     last_grant;
    grant_e     winner;
    logic       wd_clr;
    logic       wd_en;
    logic       wd_expired;
    logic       resp_ok;

    always_comb begin
        winner  = pick_winner(a_en, b_en, last_grant);
        wd_clr  = (state == IDLE);
        wd_en   = (state == ACCESS);
        // Error wins over a simultaneous ready.
        resp_ok = mem_ready && !mem_error;
    end

    elbeth_mem_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expired(wd_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= GNT_A;
            last_grant <= GNT_B;
            mem_en     <= 1'b0;
            mem_addr   <= '0;
            mem_rw     <= RW_READ;
            mem_wdata  <= '0;
            a_rdata    <= '0;
            b_rdata    <= '0;
            a_ready    <= 1'b0;
            a_error    <= 1'b0;
            b_ready    <= 1'b0;
            b_error    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            a_ready <= 1'b0;
            a_error <= 1'b0;
            b_ready <= 1'b0;
            b_error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (a_en || b_en) begin
                        grant      <= winner;
                        last_grant <= winner;
                        if (winner == GNT_A) begin
                            mem_addr  <= a_addr;
                            mem_rw    <= a_rw;
                            mem_wdata <= a_wdata;
                        end else begin
                            mem_addr  <= b_addr;
                            mem_rw    <= b_rw;
                            mem_wdata <= b_wdata;
                        end
                        mem_en <= 1'b1;
                        busy   <= 1'b1;
                        state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_error || mem_ready || wd_expired) begin
                        mem_en <= 1'b0;
                        state  <= RESP;
                        if (grant == GNT_A) begin
                            a_ready <= resp_ok;
                            a_error <= !resp_ok;
                            if (resp_ok) begin
                                a_rdata <= mem_rdata;
                            end
                        end else begin
                            b_ready <= resp_ok;
                            b_error <= !resp_ok;
                            if (resp_ok) begin
                                b_rdata <= mem_rdata;
                            end
                        end
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy   <= 1'b0;
                    mem_en <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elbeth_memory_arbiter.sv
// Randomized self-checking bench for elbeth_memory_arbiter against a transaction-level model.
module tb_elbeth_memory_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_en, b_en;
    logic [7:0]  a_addr, b_addr;
    logic [3:0]  a_rw, b_rw;
    logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata;
    logic        a_ready, a_error, b_ready, b_error;
    logic        mem_en;
    logic [7:0]  mem_addr;
    logic [3:0]  mem_rw;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ready, mem_error, busy;

    always #5 clk = ~clk;

    elbeth_memory_arbiter #(
        .ADDR_W (8),
        .DATA_W (32),
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a_en     (a_en),
        .a_addr   (a_addr),
        .a_rw     (a_rw),
        .a_wdata  (a_wdata),
        .a_rdata  (a_rdata),
        .a_ready  (a_ready),
        .a_error  (a_error),
        .b_en     (b_en),
        .b_addr   (b_addr),
        .b_rw     (b_rw),
        .b_wdata  (b_wdata),
        .b_rdata  (b_rdata),
        .b_ready  (b_ready),
        .b_error  (b_error),
        .mem_en   (mem_en),
        .mem_addr (mem_addr),
        .mem_rw   (mem_rw),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .mem_error(mem_error),
        .busy     (busy)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    int          last_g;          // model: 0 = A granted last, 1 = B
    logic [31:0] exp_rd [2];      // model: last good read data per port
    int          pend   [2];
    logic [7:0]  r_addr [2];
    logic [3:0]  r_rw   [2];
    logic [31:0] r_wd   [2];
    logic        r_en   [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // mode: 0 ready, 1 error, 2 ready+error, 3 no answer (timeout); memory answers in ACCESS cycle d+1
    task automatic run_tx(input logic ae, input logic be, input logic [7:0] aa, input logic [7:0] ba,
                          input logic [3:0] arw, input logic [3:0] brw, input logic [31:0] awd,
                          input logic [31:0] bwd, input int mode, input int d,
                          input logic [31:0] rd, input logic drop, input logic spur,
                          output int w);
        logic [7:0]  ea;
        logic [3:0]  erw;
        logic [31:0] ewd;
        logic [3:0]  epulse;
        int          done;
        a_en = ae; a_addr = aa; a_rw = arw; a_wdata = awd;
        b_en = be; b_addr = ba; b_rw = brw; b_wdata = bwd;
        w = -1;
        if (!ae && !be) begin
            tick;
            check_eq("idle_busy", {31'd0, busy}, 32'd0);
            check_eq("idle_mem_en", {31'd0, mem_en}, 32'd0);
            return;
        end
        w      = (ae && (!be || last_g == 1)) ? 0 : 1;
        last_g = w;
        ea  = (w == 0) ? aa : ba;
        erw = (w == 0) ? arw : brw;
        ewd = (w == 0) ? awd : bwd;
        done = (mode == 3) ? int'(TO) + 1 : d + 2;
        for (int c = 1; c <= done; c++) begin
            tick;
            mem_ready = 1'b0;
            mem_error = 1'b0;
            mem_rdata = $urandom;
            if (c < done) begin
                check_eq("acc_mem_en", {31'd0, mem_en}, 32'd1);
                check_eq("acc_mem_addr", {24'd0, mem_addr}, {24'd0, ea});
                check_eq("acc_mem_rw", {28'd0, mem_rw}, {28'd0, erw});
                check_eq("acc_mem_wdata", mem_wdata, ewd);
                check_eq("acc_busy", {31'd0, busy}, 32'd1);
                check_eq("acc_pulses", {28'd0, a_ready, a_error, b_ready, b_error}, 32'd0);
                if (mode != 3 && c == d + 1) begin
                    mem_ready = (mode != 1);
                    mem_error = (mode != 0);
                    mem_rdata = rd;
                end
                if (drop && c == 1) begin
                    if (w == 0) a_en = 1'b0;
                    else b_en = 1'b0;
                end
            end else begin
                if (mode == 0) exp_rd[w] = rd;
                if (w == 0) epulse = (mode == 0) ? 4'b1000 : 4'b0100;
                else epulse = (mode == 0) ? 4'b0010 : 4'b0001;
                check_eq("resp_pulses", {28'd0, a_ready, a_error, b_ready, b_error},
                         {28'd0, epulse});
                check_eq("resp_a_rdata", a_rdata, exp_rd[0]);
                check_eq("resp_b_rdata", b_rdata, exp_rd[1]);
                check_eq("resp_mem_en", {31'd0, mem_en}, 32'd0);
                check_eq("resp_busy", {31'd0, busy}, 32'd1);
                // Late answers during RESP and the following IDLE must be ignored.
                mem_ready = spur;
                mem_error = spur & $urandom_range(0, 1);
            end
        end
        tick;
        check_eq("post_busy", {31'd0, busy}, 32'd0);
        check_eq("post_mem_en", {31'd0, mem_en}, 32'd0);
        check_eq("post_pulses", {28'd0, a_ready, a_error, b_ready, b_error}, 32'd0);
        check_eq("post_a_rdata", a_rdata, exp_rd[0]);
        check_eq("post_b_rdata", b_rdata, exp_rd[1]);
    endtask

    initial begin
        int w;
        rst = 1'b0;
        a_en = 0; a_addr = 0; a_rw = 0; a_wdata = 0;
        b_en = 0; b_addr = 0; b_rw = 0; b_wdata = 0;
        mem_rdata = 0; mem_ready = 0; mem_error = 0;
        last_g = 1;
        exp_rd[0] = 0;
        exp_rd[1] = 0;
        tick;
        tick;
        check_eq("rst_ctrl", {25'd0, mem_en, busy, a_ready, a_error, b_ready, b_error, 1'b0},
                 32'd0);
        check_eq("rst_mem", {20'd0, mem_addr, mem_rw}, 32'd0);
        check_eq("rst_wdata", mem_wdata, 32'd0);
        check_eq("rst_rdata", a_rdata | b_rdata, 32'd0);
        rst = 1'b1;
        tick;

        // Single A read, minimum latency.
        run_tx(1, 0, 8'h10, 8'h00, 4'h0, 4'h0, 32'h0, 32'h0, 0, 0, 32'hDEADBEEF, 0, 0, w);
        check_eq("grant_1", w, 0);
        // Tie after an A grant goes to B: a write held stable for several cycles.
        run_tx(1, 1, 8'h20, 8'hFF, 4'h0, 4'b0011, 32'h0, 32'h12345678, 0, 3, 32'h0BADF00D, 0, 0,
               w);
        check_eq("grant_2", w, 1);
        // Tie goes back to A; memory never answers; late ready in IDLE.
        run_tx(1, 1, 8'h20, 8'h33, 4'h0, 4'h0, 32'h0, 32'h0, 3, 0, 32'h55555555, 0, 1, w);
        check_eq("grant_3", w, 0);
        // Ready and error together on B.
        run_tx(0, 1, 8'h00, 8'h33, 4'h0, 4'h0, 32'h0, 32'h0, 2, 1, 32'h77777777, 0, 0, w);
        check_eq("grant_4", w, 1);

        // Reset in the middle of an access.
        a_en = 1; a_addr = 8'h44; b_en = 0;
        mem_ready = 0; mem_error = 0;
        tick;
        tick;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_ctrl", {26'd0, mem_en, busy, a_ready, a_error, b_ready, b_error}, 32'd0);
        check_eq("mid_rst_mem", {20'd0, mem_addr, mem_rw}, 32'd0);
        check_eq("mid_rst_rdata", a_rdata | b_rdata | mem_wdata, 32'd0);
        last_g = 1;
        exp_rd[0] = 0;
        exp_rd[1] = 0;
        a_en = 0;
        tick;
        rst = 1'b1;
        tick;
        run_tx(1, 1, 8'h01, 8'h02, 4'h0, 4'h0, 32'h0, 32'h0, 0, 0, 32'hCAFE0001, 0, 0, w);
        check_eq("grant_after_rst", w, 0);
        pend[0] = 0;
        pend[1] = 1;
        r_en[1] = 1; r_addr[1] = 8'h02; r_rw[1] = 4'h0; r_wd[1] = 32'h0;

        for (int i = 0; i < 300; i++) begin
            int mode;
            for (int p = 0; p < 2; p++) begin
                if (pend[p] == 0) begin
                    r_en[p]   = ($urandom_range(0, 2) != 0);
                    r_addr[p] = 8'($urandom);
                    r_rw[p]   = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
                    r_wd[p]   = $urandom;
                end
            end
            mode = ($urandom_range(0, 5) < 3) ? 0 : int'($urandom_range(1, 3));
            run_tx(r_en[0], r_en[1], r_addr[0], r_addr[1], r_rw[0], r_rw[1], r_wd[0], r_wd[1],
                   mode, int'($urandom_range(0, TO - 1)), $urandom,
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), w);
            if (w < 0) begin
                pend[0] = 0;
                pend[1] = 0;
            end else begin
                pend[w]     = 0;
                pend[1 - w] = r_en[1 - w] ? 1 : 0;
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
